// File: rtl/sram_seq_writer_pkg.sv
// Shared constants for the sequence SRAM writer: base encoding, FSM states
// and the bases-per-word helper used by writer, loader and parsers.
package sram_seq_writer_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_HEADER,
    ST_DONE
  } wr_state_e;

  // Header word: length in [LEN_W-1:0], all upper bits zero.
  function automatic int bpw(input int word_w, input int base_w);
    return word_w / base_w;
  endfunction

endpackage

// File: rtl/sram_seq_writer_packer.sv
// Word packer: drops 2-bit codes LSB-first into lanes and flags the push
// that completes a word. word_o already contains the base being pushed.
module sram_seq_writer_packer #(
  parameter int WORD_W = 64,
  parameter int BASE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [BASE_W-1:0] base_i,
  output logic [WORD_W-1:0] word_o,
  output logic              complete_o,
  output logic              empty_o
);
  localparam int BPW    = WORD_W / BASE_W;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d;

  always_comb begin
    word_o = pack_q;
    for (int l = 0; l < BPW; l++) begin
      if (push_i && lane_q == LANE_W'(l)) word_o[l*BASE_W +: BASE_W] = base_i;
    end
    complete_o = push_i && (lane_q == LANE_W'(BPW - 1));
    pack_d     = pack_q;
    lane_d     = lane_q;
    if (clear_i || complete_o) begin
      pack_d = '0;
      lane_d = '0;
    end else if (push_i) begin
      pack_d = word_o;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  assign empty_o = (lane_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/sram_seq_writer.sv
// Host-side writer for the T/Q sequence SRAMs: packs a base stream into words
// at base+1.. and finishes with a length header at base.
module sram_seq_writer
  import sram_seq_writer_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int ADDR_W    = 16,
  parameter int BASE_W    = 2,
  parameter int LEN_W     = 16,
  parameter int MAX_BASES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              sel_T_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [BASE_W-1:0] base_i,
  input  logic              base_valid_i,
  input  logic              last_i,
  output logic              base_ready_o,
  output logic              wen_o,
  output logic              sel_T_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  len_o
);
  wr_state_e         state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pk_clear, pk_push, pk_complete, pk_empty;
  logic [WORD_W-1:0] pk_word;

  sram_seq_writer_packer #(.WORD_W(WORD_W), .BASE_W(BASE_W)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (pk_clear),
    .push_i     (pk_push),
    .base_i     (base_i),
    .word_o     (pk_word),
    .complete_o (pk_complete),
    .empty_o    (pk_empty)
  );

  assign base_ready_o = (state_q == ST_FILL);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hdr_addr_d = hdr_addr_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sel_d      = sel_T_i;
          hdr_addr_d = base_addr_i;
          ptr_d      = base_addr_i + ADDR_W'(1);
          cnt_d      = '0;
          err_d      = 1'b0;
          pk_clear   = 1'b1;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (base_valid_i) begin
          if (cnt_q == LEN_W'(MAX_BASES)) begin
            // Region full: drop this base and close out what we have.
            err_d   = 1'b1;
            state_d = pk_empty ? ST_HEADER : ST_FLUSH;
          end else begin
            pk_push = 1'b1;
            cnt_d   = cnt_q + LEN_W'(1);
            // A last base on a partial word writes that word straight away,
            // so both end cases share the same write/header/done latency.
            if (pk_complete || last_i) begin
              wen_d   = 1'b1;
              addr_d  = ptr_q;
              wdata_d = pk_word;
              ptr_d   = ptr_q + ADDR_W'(1);
            end
            if (last_i) begin
              pk_clear = 1'b1;
              state_d  = ST_HEADER;
            end
          end
        end
      end
      ST_FLUSH: begin
        wen_d    = 1'b1;
        addr_d   = ptr_q;
        wdata_d  = pk_word;
        ptr_d    = ptr_q + ADDR_W'(1);
        pk_clear = 1'b1;
        state_d  = ST_HEADER;
      end
      ST_HEADER: begin
        wen_d   = 1'b1;
        addr_d  = hdr_addr_q;
        wdata_d = WORD_W'(cnt_q);
        len_d   = cnt_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      hdr_addr_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hdr_addr_q <= hdr_addr_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wen_o   = wen_q;
  assign sel_T_o = sel_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign len_o   = len_q;

endmodule

// File: doc/sram_seq_writer.md
Name: sram_seq_writer

Overview:
- Host-side writer for the T/Q sequence SRAMs that the aligner's loader reads.
- Accepts a stream of 2-bit nucleotide codes over a valid/ready handshake and packs them LSB-first into SRAM words.
- Writes one sequence as a length header word at the base address, followed by packed data words at consecutive addresses.
- Sits between the host/DMA front end and the SRAM write port. It fills memory before the aligner's start_i is pulsed.

Parameters:
- WORD_W, 64, SRAM word width in bits; must be a multiple of BASE_W.
- ADDR_W, 16, SRAM address width.
- BASE_W, 2, bits per nucleotide code.
- LEN_W, 16, header length field width.
- MAX_BASES, 4096, capacity of one sequence region, in bases.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse that opens a sequence; sampled only in IDLE
- sel_T_i  in  1  target memory (1) or query memory (0); latched on start
- base_addr_i  in  ADDR_W  header address; latched on start
- base_i  in  BASE_W  nucleotide code
- base_valid_i  in  1  base_i is valid
- last_i  in  1  qualifies the final base of the sequence
- base_ready_o  out  1  writer accepts a base this cycle
- wen_o  out  1  SRAM write strobe, one cycle per word
- sel_T_o  out  1  latched memory select
- addr_o  out  ADDR_W  write address
- wdata_o  out  WORD_W  write data
- busy_o  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle pulse after the header write
- err_o  out  1  sticky capacity overflow flag; cleared by the next start
- len_o  out  LEN_W  base count of the last completed sequence

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; lane counter, length counter and packing register all 0.
- Constant: BPW = WORD_W/BASE_W bases per word (32 at the defaults).
- A base is accepted when base_valid_i && base_ready_o.
- FSM states: IDLE, FILL, FLUSH, HEADER, DONE.
- IDLE
  - base_ready_o = 0.
  - On start_i: latch sel_T_i and base_addr_i; set the data pointer to base_addr+1; clear length, lane, packing register and err_o; go to FILL.
- FILL
  - base_ready_o = 1.
  - Each accepted base is written into lane[lane_cnt] of the packing register, at bits lane*BASE_W+:BASE_W.
  - Each accepted base increments lane_cnt and length.
  - When lane BPW-1 is accepted:
    - the next cycle drives wen_o=1, addr_o = data pointer, wdata_o = the full word;
    - the data pointer increments;
    - the packing register clears;
    - acceptance continues in that same cycle without a stall.
  - Accepted base with last_i:
    - If it filled a word, the word write issues as above, then go to HEADER.
    - Otherwise go to FLUSH.
  - Overflow: if length == MAX_BASES and a further base is accepted:
    - the base is dropped;
    - err_o is set;
    - go to FLUSH, or HEADER if lane_cnt==0.
- FLUSH
  - base_ready_o = 0.
  - One cycle: write the partial word with unused upper lanes 0 at the data pointer.
  - Go to HEADER.
- HEADER
  - base_ready_o = 0.
  - One cycle: wen_o=1, addr_o = base_addr, wdata_o = zero-extended length.
  - Latch len_o. Go to DONE.
- DONE
  - One cycle: done_o=1, busy_o=0.
  - Go to IDLE. A start_i arriving in this cycle is ignored.
- Latency: the last base is accepted at cycle N. FLUSH write is at N+1, header at N+2, done_o at N+3. For an exact word boundary, the data write is at N+1, header at N+2, done_o at N+3.
- Output registers: wen_o, addr_o and wdata_o are registered. wen_o is never high two cycles in a row except for a data write followed by the header.
- Address arithmetic wraps modulo 2^ADDR_W. There is no bound check against the region; software owns the layout.
- start_i while busy is ignored.
- base_valid_i outside FILL is ignored; no base is consumed.
- Every sequence holds at least one base. Empty sequences are not supported.
- Reset mid-operation: immediate return to IDLE with wen_o=0. A partial sequence leaves SRAM contents undefined.

Decomposition:
- Shared package (the existing parameter include) holds:
  - the base encoding constants (A=0, C=1, G=2, T=3);
  - the header word layout (length in bits [LEN_W-1:0], rest 0);
  - the BPW macro.
- The aligner's loader and parsers use the same constants.
- One natural sub-module, seq_word_packer: lane counter, packing register and word-complete strobe. The top level holds the FSM, the address pointer and the length/error logic.

Test Plan:
- Start with sel_T_i=1, base_addr_i=0x10, then 3 bases C,G,T, last on T → data write at 0x11 with wdata=0x39; header write at 0x10 with wdata=3; done_o, len_o=3, sel_T_o=1.
- Exactly 32 bases, all G, last on the 32nd → one write at base+1 of 0xAAAA_AAAA_AAAA_AAAA, no FLUSH, header=32, done_o three cycles after the last base.
- 33 bases of A with base_valid_i toggled every other cycle → writes at base+1 (all zeros) and base+2 (lane 0 only), header=33, base_ready_o never low during FILL.
- MAX_BASES=64, 65 bases supplied → header=64, err_o=1, no write at base+3, FSM returns to IDLE; the next start clears err_o.
- Assert rst_n low mid-FILL after 10 bases → all outputs 0 immediately; a new start writes a correct header and data.
- base_addr_i=0xFFFF with 40 bases → data words at 0x0000 and 0x0001, header at 0xFFFF.
